// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// FSM state encoding and legal oversampling ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority vote around the middle of each bit.
// In: CLK, RST, rx_s, edge_cnt, prescale. Out: sampled_bit, sample_done.
module uart_rx_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_s,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] prescale,
  output logic       sampled_bit,
  output logic       sample_done
);

  logic [2:0] s;
  logic [6:0] e2;
  logic [6:0] p7;

  // Compare 2*edge_cnt with P-2, P, P+2 to avoid halving prescale.
  assign e2 = {edge_cnt, 1'b0};
  assign p7 = {1'b0, prescale};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s           <= 3'b111;
      sample_done <= 1'b0;
    end else begin
      sample_done <= (e2 == p7 + 7'd2);
      if (e2 == p7 - 7'd2) s[0] <= rx_s;
      if (e2 == p7)        s[1] <= rx_s;
      if (e2 == p7 + 7'd2) s[2] <= rx_s;
    end
  end

  assign sampled_bit = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: sync, oversampled bit recovery, frame FSM, error pulses.
// In: CLK, RST, RX_IN, prescale, party_en, party_typ. Out: P_DATA, pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  party_en,
  input  logic                  party_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  state_t                state;
  logic [1:0]            sync;
  logic                  rx_s;
  logic [5:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [5:0]            pre_q;
  logic                  pen_q;
  logic                  ptyp_q;
  logic                  par_flag;
  logic                  bit_q;
  logic [DATA_WIDTH-1:0] sh;
  logic                  sampled_bit;
  logic                  sample_done;
  logic                  last;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync <= 2'b11;
    else      sync <= {sync[0], RX_IN};
  end

  assign rx_s = sync[1];
  assign last = (edge_cnt == pre_q - 6'd1);

  uart_rx_sampler u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .rx_s        (rx_s),
    .edge_cnt    (edge_cnt),
    .prescale    (pre_q),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      pre_q      <= PRESCALE_8;
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      par_flag   <= 1'b0;
      bit_q      <= 1'b1;
      sh         <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (sample_done) bit_q <= sampled_bit;
      if (state != IDLE) edge_cnt <= last ? 6'd0 : edge_cnt + 6'd1;
      unique case (state)
        IDLE: begin
          // The detecting cycle itself is edge 0 of the start bit.
          if (!rx_s) begin
            state    <= START;
            edge_cnt <= 6'd1;
            pre_q    <= prescale;
            pen_q    <= party_en;
            ptyp_q   <= party_typ;
            par_flag <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (last) state <= bit_q ? IDLE : DATA;
        end
        DATA: begin
          if (last) begin
            sh      <= {bit_q, sh[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_WIDTH - 1))
              state <= pen_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (last) begin
            par_flag <= (^sh) ^ bit_q ^ ptyp_q;
            state    <= STOP;
          end
        end
        STOP: begin
          if (last) begin
            state   <= IDLE;
            stp_err <= ~bit_q;
            par_err <= par_flag;
            if (bit_q && !par_flag) begin
              data_valid <= 1'b1;
              P_DATA     <= sh;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous serial line into `DATA_WIDTH`-bit parallel words. It is the receive-side counterpart of the existing UART transmitter and uses the same frame: start bit, LSB-first data, optional parity, one stop bit. A 2-flop synchroniser and majority-vote oversampling feed a control FSM, which reports parity and stop errors. It sits between the external RX pad and the register/FIFO layer that consumes received bytes.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `CLK` input, 1 bit: oversampling clock, equal to bit rate × `prescale`.
- `RST` input, 1 bit: reset, asynchronous, active-low.
- `RX_IN` input, 1 bit: serial line, idle high, asynchronous to `CLK`.
- `prescale` input, 6 bits: oversampling ratio. Legal values are 8, 16 and 32. The value is captured at start detection and held for the whole frame.
- `party_en` input, 1 bit: 1 means a parity bit is present. Captured at start detection.
- `party_typ` input, 1 bit: 0 selects even parity, 1 selects odd. Captured at start detection.
- `P_DATA` output, `DATA_WIDTH` bits: last good received word.
- `data_valid` output, 1 bit: one-cycle pulse marking a new good word on `P_DATA`.
- `par_err` output, 1 bit: one-cycle pulse marking a parity mismatch.
- `stp_err` output, 1 bit: one-cycle pulse marking that the stop bit was sampled as 0.

## Operation
- **Reset:** all outputs go to 0, the FSM goes to IDLE, both synchroniser flops go to 1, and all counters clear.
- **Synchroniser:** `RX_IN` passes through 2 flops to give `rx_s`. All behaviour below refers to `rx_s`.
- **Counters:**
  - `edge_cnt` counts 0..`prescale`-1 within each bit.
  - `bit_cnt` indexes bits within the frame.
- **Sampling:** samples are taken at `edge_cnt` = P/2-1, P/2 and P/2+1 (P = captured prescale). The bit value is the majority of the three and is valid from `edge_cnt` = P/2+2.
- **FSM states:**
  - IDLE: when `rx_s`=0, go to START. This cycle is `edge_cnt`=0.
  - START: if the sampled bit is 1, treat it as a glitch and return to IDLE at `edge_cnt`=P-1. Otherwise go to DATA at `edge_cnt`=P-1.
  - DATA: shift the sampled bit into `P_DATA` position `bit_cnt`, LSB first. After bit `DATA_WIDTH`-1, go to PARITY if `party_en`=1, else go to STOP.
  - PARITY: compute XOR of the data bits XOR the parity bit. A mismatch occurs when this is nonzero for even parity, or zero for odd parity. Record the result in an internal flag. Go to STOP at `edge_cnt`=P-1.
  - STOP: at `edge_cnt`=P-1, go to IDLE and issue the result pulses.
- **Result pulses** (all in the same cycle):
  - `stp_err`=1 if the stop bit sampled 0.
  - `par_err`=1 if the parity flag is set.
  - `data_valid`=1 only if neither error is set.
- **Output register:** `P_DATA` updates only on a good frame. The shift occurs in an internal register that is copied to `P_DATA` at `data_valid`.
- **Back-to-back frames:** IDLE accepts a new start in its first cycle, so zero idle bits between frames is supported.
- **Illegal prescale:** behaviour with an illegal `prescale` value is undefined. Verification does not test it.

## Timing
- Frame length is N = 1 + `DATA_WIDTH` + `party_en` + 1 bits.
- START entry is cycle 0, defined as the first cycle in which `rx_s`=0 is seen in IDLE.
- The result pulses occur in cycle N·P. This is registered and lasts exactly 1 cycle.
- Pad-to-`rx_s` latency is 2 cycles. Total latency from the start-bit falling edge on `RX_IN` to the pulse is N·P+2 cycles.
- When `RST` is asserted mid-frame, the frame is abandoned immediately: no pulse is issued and `P_DATA` returns to 0. After release, the block resumes in IDLE and waits for the next falling edge.
- A line held low (break) produces the start, then data 0, then `stp_err`. Afterwards IDLE sees `rx_s`=0 and re-enters START. This repeats every N·P cycles until the line returns high.

## Structure
- Package `uart_rx_pkg` holds:
  - The state enum: IDLE, START, DATA, PARITY, STOP.
  - The legal prescale constants: 8, 16, 32.
- Sub-module `uart_rx_sampler` contains the 3-sample majority vote. Inputs: `CLK`, `RST`, `rx_s`, `edge_cnt`, `prescale`. Outputs: `sampled_bit`, `sample_done`.
- The top level contains the FSM, the counters, the shift register, the parity check and the output registers.

## Test plan
- **Good frame, no parity:** P=8, `party_en`=0, send 0xA5. Expect `data_valid` pulse at cycle 80 after START, `P_DATA`=0xA5, no errors.
- **Even parity, correct:** P=16, `party_en`=1, `party_typ`=0, send 0x3C with parity 0. Expect `data_valid` at cycle 176, `P_DATA`=0x3C.
- **Odd parity, wrong bit:** P=8, `party_typ`=1, send 0x01 with parity 1. Expect `par_err` pulse, no `data_valid`, `P_DATA` unchanged.
- **Stop error and glitch:**
  - Send 0x55 with stop bit 0. Expect `stp_err` pulse only.
  - Separately, drive `RX_IN` low for 2 cycles at P=16. Expect no pulse, and the FSM back in IDLE.
- **Back-to-back frames:** P=32, send 0xC3 then 0x18 with no idle gap. Expect two `data_valid` pulses exactly 320 cycles apart, carrying 0xC3 then 0x18.
- **Reset mid-frame:** assert `RST`=0 during DATA bit 4. Expect all outputs 0 and no pulse. The next full frame 0x7E is received correctly.
